// File: rtl/cpu_mem_responder.sv
// Byte-wide RAM responder for the CPU bus: stalls via cpu_enable=0 for 1+nbytes*(1+WAIT_STATES) cycles, then one DONE cycle.
// Optional CPU_MEM_RESP_ALIGN_CHECK_EN rejects misaligned 16b/32b accesses with bus_err and no RAM access.
module cpu_mem_responder #(
  parameter int MEM_DEPTH_LOG2 = 16,
  parameter int WAIT_STATES    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [1:0]  req_sz,
  input  logic [31:0] req_addr,
  input  logic [47:0] req_wr_data,
  output logic [47:0] cpu_data_in,
  output logic        cpu_enable,
  output logic        bus_err
);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                    state_q, state_d;
  logic [MEM_DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [1:0]                sz_q, sz_d;
  logic [47:0]               wdat_q, wdat_d;
  logic                      wr_q, wr_d;
  logic [2:0]                bcnt_q, bcnt_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic [47:0]               data_q, data_d;
  logic                      err_q, err_d;

  logic [7:0]                mem [0:DEPTH-1];
  logic [MEM_DEPTH_LOG2-1:0] mem_idx;
  logic [7:0]                rd_byte;
  logic [7:0]                wr_byte;
  logic                      mem_we;
  logic [2:0]                nbytes;
  logic                      req_any;
  logic                      req_bad;
  logic                      misalign;
  logic                      beat;
  logic                      unused_addr;

  assign unused_addr = ^req_addr[31:MEM_DEPTH_LOG2];

  assign req_any = req_rd | req_wr;
  assign req_bad = req_rd & req_wr;

`ifdef CPU_MEM_RESP_ALIGN_CHECK_EN
  assign misalign = ((req_sz == 2'd1) && req_addr[0]) ||
                    ((req_sz == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    case (sz_q)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd6;
    endcase
  end

  // Natural-width add wraps the byte address modulo the RAM size.
  assign mem_idx = addr_q + MEM_DEPTH_LOG2'(bcnt_q);
  assign rd_byte = mem[mem_idx];
  assign wr_byte = wdat_q[8*int'(bcnt_q) +: 8];
  assign beat    = (state_q == ACCESS) && (wcnt_q == 4'(WAIT_STATES));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sz_d    = sz_q;
    wdat_d  = wdat_q;
    wr_d    = wr_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          addr_d = req_addr[MEM_DEPTH_LOG2-1:0];
          sz_d   = req_sz;
          wdat_d = req_wr_data;
          wr_d   = req_wr;
          bcnt_d = 3'd0;
          wcnt_d = 4'd0;
          if (req_bad || misalign) begin
            err_d   = 1'b1;
            data_d  = 48'd0;
            state_d = DONE;
          end else begin
            if (!req_wr) data_d = 48'd0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (beat) begin
          if (wr_q) mem_we = 1'b1;
          else      data_d[8*int'(bcnt_q) +: 8] = rd_byte;
          bcnt_d = bcnt_q + 3'd1;
          wcnt_d = 4'd0;
          if (bcnt_q == nbytes - 3'd1) state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sz_q    <= 2'd0;
      wdat_q  <= 48'd0;
      wr_q    <= 1'b0;
      bcnt_q  <= 3'd0;
      wcnt_q  <= 4'd0;
      data_q  <= 48'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sz_q    <= sz_d;
      wdat_q  <= wdat_d;
      wr_q    <= wr_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset; state_q is forced to IDLE so no write fires while rst_n is low.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= wr_byte;
  end

  assign cpu_enable  = rst_n && (((state_q == IDLE) && !req_any) || (state_q == DONE));
  assign cpu_data_in = data_q;
  assign bus_err     = err_q;

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU's data/instruction bus: services CPU read/write requests from a byte-wide internal RAM and returns the read data on the CPU's `data_in`.
- Drives the CPU's `enable` input low to stall the CPU until the access completes.
- Models a narrow, slow memory: one byte per access beat, with optional wait states, little-endian.
- Sits between Cpu and the (future) system bus; used as the default simulation/FPGA memory.

Parameters:
- MEM_DEPTH_LOG2, 16, RAM size = 2**MEM_DEPTH_LOG2 bytes; addresses are taken modulo this size.
- WAIT_STATES, 0, extra idle cycles before each byte beat (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_rd  in  1  CPU read request; held stable by the CPU while cpu_enable=0.
- req_wr  in  1  CPU write request; held stable by the CPU while cpu_enable=0.
- req_sz  in  2  access size: 0=8b, 1=16b, 2=32b, 3=48b (instruction fetch).
- req_addr  in  32  byte address.
- req_wr_data  in  48  write data, little-endian; only the low req_sz bytes are used.
- cpu_data_in  out  48  read data to the CPU `data_in`; unused upper bytes are 0.
- cpu_enable  out  1  to the CPU `enable`; 0 = stall.
- bus_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Byte count: nbytes = 1, 2, 4, 6 for req_sz = 0, 1, 2, 3.
- cpu_enable is combinational:
  - 1 in IDLE when req_rd=req_wr=0.
  - 1 in DONE.
  - 0 otherwise.
  - Forced to 0 while rst_n=0.
- IDLE with (req_rd|req_wr)=1:
  - Stall this cycle.
  - At the edge, latch addr, size, wr_data and op.
  - Clear byte counter bcnt and wait counter wcnt; go to ACCESS.
  - If a read, clear the read-assembly register.
- Simultaneous req_rd and req_wr:
  - Set bus_err.
  - No RAM access; skip ACCESS and go directly to DONE.
  - cpu_data_in = 0.
- ACCESS:
  - wcnt counts 0..WAIT_STATES; the beat occurs on the edge where wcnt==WAIT_STATES.
  - Beat, read: byte RAM[(addr+bcnt) mod depth] (combinational RAM read) is placed at bits [8*bcnt+7 : 8*bcnt].
  - Beat, write: RAM[(addr+bcnt) mod depth] <= wr_data[8*bcnt+7 : 8*bcnt].
  - After each beat, bcnt++ and wcnt=0.
  - After beat nbytes-1, go to DONE.
- Address wrap: (addr+bcnt) wraps modulo depth, so a 6-byte fetch at depth-2 reads bytes depth-2, depth-1, 0, 1, 2, 3.
- DONE:
  - cpu_enable=1 for exactly one cycle.
  - cpu_data_in holds the assembled read data (unchanged for writes).
  - Next state is IDLE unconditionally.
  - The CPU updates its request at this edge, so the request seen in the following IDLE cycle is new.
- cpu_data_in holds its value from DONE until the next read's latch edge.
- Stall length per access = 1 + nbytes*(1+WAIT_STATES) cycles, followed by one DONE cycle.
  - With WAIT_STATES=0, a 32b read stalls 5 cycles.
- Reset (async, any state, including mid-access):
  - State goes to IDLE.
  - cpu_data_in=0, bus_err=0, counters=0.
  - Bytes already written by an aborted write remain; no further writes occur.
  - RAM contents are not reset.
- Back-to-back requests: IDLE → ACCESS with no extra bubble beyond the single IDLE stall cycle.

Optional Feature:
- Macro: CPU_MEM_RESP_ALIGN_CHECK_EN.
- Defined:
  - A 16b access with addr[0]!=0 is misaligned.
  - A 32b access with addr[1:0]!=0 is misaligned.
  - On a misaligned access, set bus_err, perform no RAM access, go directly to DONE, and return cpu_data_in=0.
  - 8b and 48b accesses are unchecked.
- Undefined: misaligned accesses proceed normally byte by byte; bus_err is set only by simultaneous rd/wr.

Test Plan:
- Reset, then write req_sz=2, addr=0x10, data=0x0000_DEADBEEF with WAIT_STATES=0 → cpu_enable low 5 cycles, high 1 cycle; RAM[0x10..0x13] = EF, BE, AD, DE.
- Read req_sz=2 at addr=0x10 → after 5 stall cycles, DONE cycle shows cpu_data_in = 0x0000_DEADBEEF and cpu_enable=1.
- With WAIT_STATES=2, a 48b fetch at addr=0xFFFE (MEM_DEPTH_LOG2=16) → stall 1+6*3 = 19 cycles; bytes wrap to 0x0000..0x0003; result = {RAM[3], RAM[2], RAM[1], RAM[0], RAM[FFFF], RAM[FFFE]}.
- req_rd=req_wr=1 → bus_err=1 after the latch edge; DONE follows on the next cycle; cpu_data_in=0; RAM unchanged.
- Assert rst_n=0 mid-way through a 32b write after 2 beats → cpu_enable=0 during reset; after release, state is IDLE, only the first 2 bytes are written, bus_err=0.
- With CPU_MEM_RESP_ALIGN_CHECK_EN defined, a 32b read at addr=0x11 → bus_err=1, cpu_data_in=0, stall 1 cycle then DONE. Without the macro, the same read returns bytes 0x11..0x14 normally.
